// File: rtl/sdrc_wb_burst_master_pkg.sv
`default_nettype none
// ============================================================================
// Package   : sdrc_wb_pkg
// Purpose   : Shared Wishbone cycle-type codes and FSM state encoding for the
//             SDRAM-controller Wishbone burst master.
// Revision  : 1.0  initial release
// ============================================================================
package sdrc_wb_pkg;

    // Wishbone B3 cycle type identifiers
    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    // Burst master control states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        FINISH = 2'd2
    } state_e;

endpackage : sdrc_wb_pkg
`default_nettype wire

// File: rtl/sdrc_wb_burst_master.sv
`default_nettype none
// ============================================================================
// Module    : sdrc_wb_burst_master
// Purpose   : Wishbone B3 incrementing-burst master. Turns a command plus a
//             write-data stream into one Wishbone burst per command and
//             returns read beats as a one-cycle-latency stream. A stalled
//             slave is abandoned after TIMEOUT unacknowledged STB cycles.
// Revision  : 1.0  initial release
// ============================================================================
module sdrc_wb_burst_master
    import sdrc_wb_pkg::*;
#(
    parameter int SDR_DW  = 32,
    parameter int APP_AW  = 26,
    parameter int LEN_W   = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    // command interface
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_we,
    input  logic [APP_AW-1:0]     cmd_addr,
    input  logic [LEN_W-1:0]      cmd_len,
    // write-data stream
    input  logic                  wdat_valid,
    output logic                  wdat_ready,
    input  logic [SDR_DW-1:0]     wdat,
    // read-data stream and completion
    output logic                  rdat_valid,
    output logic [SDR_DW-1:0]     rdat,
    output logic                  done,
    output logic                  err,
    // Wishbone master port
    output logic                  wb_cyc_o,
    output logic                  wb_stb_o,
    output logic                  wb_we_o,
    output logic [APP_AW-1:0]     wb_addr_o,
    output logic [SDR_DW/8-1:0]   wb_sel_o,
    output logic [2:0]            wb_cti_o,
    output logic [SDR_DW-1:0]     wb_dat_o,
    input  logic                  wb_ack_i,
    input  logic [SDR_DW-1:0]     wb_dat_i
);

    localparam int                SEL_W      = SDR_DW / 8;
    localparam int                TO_W       = $clog2(TIMEOUT + 1);
    localparam logic [APP_AW-1:0] BEAT_BYTES = APP_AW'(SEL_W);
    localparam logic [APP_AW-1:0] ALIGN_MASK = ~APP_AW'(SEL_W - 1);
    localparam logic [TO_W-1:0]   TO_LAST    = TO_W'(TIMEOUT - 1);

    state_e              state_q, state_d;
    logic                cyc_q, cyc_d;
    logic                stb_q, stb_d;
    logic                we_q, we_d;
    logic [APP_AW-1:0]   addr_q, addr_d;
    logic [2:0]          cti_q, cti_d;
    logic [SDR_DW-1:0]   dat_q, dat_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic                rdat_valid_q, rdat_valid_d;
    logic [SDR_DW-1:0]   rdat_q, rdat_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [TO_W-1:0]     to_q;

    logic                w_accept;
    logic                w_beat_ack;
    logic                w_last_ack;
    logic                w_timeout;
    logic                w_load;

    // An ACK only counts while our own strobe is up; stray ACKs are ignored.
    assign w_accept   = cmd_valid && (state_q == IDLE);
    assign w_beat_ack = (state_q == ISSUE) && stb_q && wb_ack_i;
    assign w_last_ack = w_beat_ack && (cnt_q == '0);
    assign w_timeout  = (state_q == ISSUE) && stb_q && !wb_ack_i && (to_q == TO_LAST);
    // A write beat is pulled either into an idle strobe slot or straight
    // behind an acknowledged beat, but never past the final beat.
    assign w_load     = (state_q == ISSUE) && we_q && wdat_valid &&
                        (!stb_q || (w_beat_ack && (cnt_q != '0)));

    // State register
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (w_accept) state_d = ISSUE;
            ISSUE:   if (w_last_ack || w_timeout) state_d = FINISH;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values for the registered Wishbone and stream outputs
    always_comb begin
        cyc_d        = cyc_q;
        stb_d        = stb_q;
        we_d         = we_q;
        addr_d       = addr_q;
        cti_d        = cti_q;
        dat_d        = dat_q;
        cnt_d        = cnt_q;
        rdat_valid_d = w_beat_ack && !we_q;
        rdat_d       = (w_beat_ack && !we_q) ? wb_dat_i : rdat_q;
        done_d       = 1'b0;
        err_d        = 1'b0;
        case (state_q)
            IDLE: begin
                if (w_accept) begin
                    cyc_d  = 1'b1;
                    // reads strobe at once; writes wait for their first beat
                    stb_d  = !cmd_we;
                    we_d   = cmd_we;
                    addr_d = cmd_addr & ALIGN_MASK;
                    cnt_d  = cmd_len;
                    cti_d  = (cmd_len == '0) ? CTI_EOB : CTI_INCR;
                end
            end
            ISSUE: begin
                if (w_last_ack || w_timeout) begin
                    cyc_d  = 1'b0;
                    stb_d  = 1'b0;
                    we_d   = 1'b0;
                    addr_d = '0;
                    cti_d  = CTI_CLASSIC;
                    dat_d  = '0;
                    done_d = 1'b1;
                    err_d  = w_timeout;
                end else begin
                    if (w_beat_ack) begin
                        addr_d = addr_q + BEAT_BYTES;
                        cnt_d  = cnt_q - LEN_W'(1);
                        cti_d  = (cnt_q == LEN_W'(1)) ? CTI_EOB : CTI_INCR;
                    end
                    if (we_q) begin
                        if (w_load) begin
                            stb_d = 1'b1;
                            dat_d = wdat;
                        end else if (w_beat_ack) begin
                            // write data starved: hold CYC, park STB
                            stb_d = 1'b0;
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    // Output registers
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            cyc_q        <= 1'b0;
            stb_q        <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            cti_q        <= CTI_CLASSIC;
            dat_q        <= '0;
            cnt_q        <= '0;
            rdat_valid_q <= 1'b0;
            rdat_q       <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            cyc_q        <= cyc_d;
            stb_q        <= stb_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            cti_q        <= cti_d;
            dat_q        <= dat_d;
            cnt_q        <= cnt_d;
            rdat_valid_q <= rdat_valid_d;
            rdat_q       <= rdat_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    // Unacknowledged-strobe watchdog; frozen while STB is parked low
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            to_q <= '0;
        end else if (w_accept || w_beat_ack) begin
            to_q <= '0;
        end else if ((state_q == ISSUE) && stb_q) begin
            to_q <= to_q + TO_W'(1);
        end
    end

    assign cmd_ready  = (state_q == IDLE);
    assign wdat_ready = w_load;
    assign rdat_valid = rdat_valid_q;
    assign rdat       = rdat_q;
    assign done       = done_q;
    assign err        = err_q;
    assign wb_cyc_o   = cyc_q;
    assign wb_stb_o   = stb_q;
    assign wb_we_o    = we_q;
    assign wb_addr_o  = addr_q;
    assign wb_sel_o   = '1;
    assign wb_cti_o   = cti_q;
    assign wb_dat_o   = dat_q;

endmodule : sdrc_wb_burst_master
`default_nettype wire

// File: tb/tb_sdrc_wb_burst_master.sv
`default_nettype none
// ============================================================================
// Module    : tb_sdrc_wb_burst_master
// Purpose   : Directed and randomised checks of the Wishbone burst master
//             against a behavioural Wishbone slave and write-data source.
// Revision  : 1.0  initial release
// ============================================================================
module tb_sdrc_wb_burst_master;

    localparam int DW = 32;
    localparam int AW = 26;
    localparam int LW = 8;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            cmd_valid, cmd_ready, cmd_we;
    logic [AW-1:0]   cmd_addr;
    logic [LW-1:0]   cmd_len;
    logic            wdat_valid, wdat_ready;
    logic [DW-1:0]   wdat;
    logic            rdat_valid;
    logic [DW-1:0]   rdat;
    logic            done, err;
    logic            wb_cyc_o, wb_stb_o, wb_we_o;
    logic [AW-1:0]   wb_addr_o;
    logic [DW/8-1:0] wb_sel_o;
    logic [2:0]      wb_cti_o;
    logic [DW-1:0]   wb_dat_o;
    logic            wb_ack_i;
    logic [DW-1:0]   wb_dat_i;

    sdrc_wb_burst_master #(
        .SDR_DW (DW),
        .APP_AW (AW),
        .LEN_W  (LW),
        .TIMEOUT(TO)
    ) u_dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .wdat_valid(wdat_valid),
        .wdat_ready(wdat_ready),
        .wdat      (wdat),
        .rdat_valid(rdat_valid),
        .rdat      (rdat),
        .done      (done),
        .err       (err),
        .wb_cyc_o  (wb_cyc_o),
        .wb_stb_o  (wb_stb_o),
        .wb_we_o   (wb_we_o),
        .wb_addr_o (wb_addr_o),
        .wb_sel_o  (wb_sel_o),
        .wb_cti_o  (wb_cti_o),
        .wb_dat_o  (wb_dat_o),
        .wb_ack_i  (wb_ack_i),
        .wb_dat_i  (wb_dat_i)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // observation log, filled by the slave/monitor process
    logic [AW-1:0]   b_addr[$];
    logic [2:0]      b_cti[$];
    logic            b_we[$];
    logic [DW-1:0]   b_dat[$];
    logic [DW-1:0]   rd_got[$];
    int              done_cyc[$];
    logic [DW/8-1:0] last_sel;
    logic            last_err;
    int cyc_n = 0, done_cnt = 0, cyc_rise = 0, last_rise_cyc = 0;
    int gap_cnt = 0, stb_cnt = 0, wrdy_cnt = 0;
    logic prev_cyc = 1'b0;

    // slave and write-source controls
    logic [DW-1:0] wq[$];
    int  gap = 0, pops = 0, starve_after = -1, starve_len = 0;
    bit  mute = 1'b0, rnd_ack = 1'b0;
    int  fix_delay = 0, wait_cnt = 0, cur_delay = 0;

    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        return {a, 6'b0} ^ 32'hC3A5_0F1E;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        b_addr.delete(); b_cti.delete(); b_we.delete(); b_dat.delete();
        rd_got.delete(); done_cyc.delete();
        done_cnt = 0; last_err = 1'bx; cyc_rise = 0; last_rise_cyc = 0;
        gap_cnt = 0; stb_cnt = 0; wrdy_cnt = 0;
        pops = 0; gap = 0; starve_after = -1; starve_len = 0;
    endtask

    task automatic send_cmd(input logic we, input logic [AW-1:0] a, input logic [LW-1:0] l);
        logic rdy;
        bit   took;
        took = 1'b0;
        @(negedge clk); #2;
        cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_len = l;
        for (int n = 0; n < 200; n++) begin
            rdy = cmd_ready;
            @(posedge clk); #1;
            if (rdy) begin
                took = 1'b1;
                break;
            end
        end
        cmd_valid = 1'b0;
        chk("cmd_accept", took, 1);
    endtask

    task automatic wait_done(input int target, input int max_cyc);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < max_cyc; n++) begin
            @(negedge clk); #3;
            if (done_cnt >= target) begin
                seen = 1'b1;
                break;
            end
        end
        chk("done_seen", seen, 1);
    endtask

    // Wishbone slave, write-data source and output monitor, all on the falling edge
    initial begin : bfm
        wb_ack_i = 1'b0; wb_dat_i = '0; wdat_valid = 1'b0; wdat = '0;
        forever begin
            @(negedge clk);
            cyc_n++;
            if (rdat_valid) rd_got.push_back(rdat);
            if (done) begin
                done_cnt++;
                last_err = err;
                done_cyc.push_back(cyc_n);
            end
            if (wb_cyc_o && !prev_cyc) begin
                cyc_rise++;
                last_rise_cyc = cyc_n;
            end
            prev_cyc = wb_cyc_o;
            if (wb_cyc_o && !wb_stb_o) gap_cnt++;
            if (wb_stb_o) stb_cnt++;
            if (wb_cyc_o && wb_stb_o && !mute) begin
                if (wait_cnt == 0) cur_delay = rnd_ack ? int'($urandom_range(7, 0)) : fix_delay;
                if (wait_cnt >= cur_delay) begin
                    wb_ack_i = 1'b1;
                    wb_dat_i = pat(wb_addr_o);
                    b_addr.push_back(wb_addr_o);
                    b_cti.push_back(wb_cti_o);
                    b_we.push_back(wb_we_o);
                    b_dat.push_back(wb_dat_o);
                    last_sel = wb_sel_o;
                    wait_cnt = 0;
                end else begin
                    wb_ack_i = 1'b0;
                    wait_cnt++;
                end
            end else begin
                wb_ack_i = 1'b0;
                wait_cnt = 0;
            end
            if (gap > 0) begin
                wdat_valid = 1'b0;
                gap--;
            end else if (wq.size() > 0) begin
                wdat_valid = 1'b1;
                wdat = wq[0];
            end else begin
                wdat_valid = 1'b0;
                wdat = '0;
            end
            #1;
            if (wdat_valid && wdat_ready) begin
                void'(wq.pop_front());
                pops++;
                wrdy_cnt++;
                if (pops == starve_after) gap = starve_len;
            end
        end
    end

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    logic [AW-1:0] t2_a [4];
    logic [2:0]    t2_c [4];
    logic [DW-1:0] t3_w [4];

    initial begin : main
        rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_len = '0;
        clear_log();
        #12;
        // reset state
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_cyc", wb_cyc_o, 0);
        chk("rst_stb", wb_stb_o, 0);
        chk("rst_we", wb_we_o, 0);
        chk("rst_addr", wb_addr_o, 0);
        chk("rst_sel", wb_sel_o, 4'hF);
        chk("rst_cti", wb_cti_o, 3'b000);
        chk("rst_dat", wb_dat_o, 0);
        chk("rst_rdat_valid", rdat_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_wdat_ready", wdat_ready, 0);
        @(negedge clk);
        rst = 1'b0;

        // single write, slave waits 2 cycles
        clear_log(); fix_delay = 2;
        wq.push_back(32'hA5A5_A5A5);
        send_cmd(1'b1, 26'h100, 8'd0);
        wait_done(1, 50);
        chk("t1_beats", b_addr.size(), 1);
        if (b_addr.size() >= 1) begin
            chk("t1_addr", b_addr[0], 26'h100);
            chk("t1_cti", b_cti[0], 3'b111);
            chk("t1_dat", b_dat[0], 32'hA5A5_A5A5);
            chk("t1_we", b_we[0], 1);
        end
        chk("t1_sel", last_sel, 4'hF);
        chk("t1_err", last_err, 0);
        chk("t1_wrdy", wrdy_cnt, 1);
        chk("t1_stb_cycles", stb_cnt, 3);
        repeat (3) @(negedge clk);
        #3;
        chk("t1_done_pulse", done_cnt, 1);
        chk("t1_cmd_ready", cmd_ready, 1);

        // read burst wrapping the address space, zero-wait slave
        clear_log(); fix_delay = 0;
        t2_a = '{26'h3FF_FFF8, 26'h3FF_FFFC, 26'h000_0000, 26'h000_0004};
        t2_c = '{3'b010, 3'b010, 3'b010, 3'b111};
        send_cmd(1'b0, 26'h3FF_FFF8, 8'd3);
        wait_done(1, 50);
        chk("t2_beats", b_addr.size(), 4);
        chk("t2_rd_count", rd_got.size(), 4);
        for (int k = 0; k < 4; k++) begin
            if (k < b_addr.size()) begin
                chk("t2_addr", b_addr[k], t2_a[k]);
                chk("t2_cti", b_cti[k], t2_c[k]);
            end
            if (k < rd_got.size()) chk("t2_rdat", rd_got[k], pat(t2_a[k]));
        end
        chk("t2_err", last_err, 0);

        // write with data starvation after the first beat
        clear_log(); fix_delay = 0;
        t3_w = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
        for (int k = 0; k < 4; k++) wq.push_back(t3_w[k]);
        starve_after = 1; starve_len = 5;
        send_cmd(1'b1, 26'h2000, 8'd3);
        wait_done(1, 100);
        chk("t3_wrdy", wrdy_cnt, 4);
        chk("t3_beats", b_dat.size(), 4);
        for (int k = 0; k < 4; k++) begin
            if (k < b_dat.size()) chk("t3_dat", b_dat[k], t3_w[k]);
        end
        if (b_addr.size() == 4) chk("t3_last_addr", b_addr[3], 26'h200C);
        chk("t3_gap_cycles", gap_cnt, 6);
        chk("t3_cyc_rises", cyc_rise, 1);
        chk("t3_err", last_err, 0);

        // timeout: slave never answers
        clear_log(); mute = 1'b1;
        send_cmd(1'b0, 26'h40, 8'd1);
        wait_done(1, 60);
        mute = 1'b0;
        chk("t4_stb_cycles", stb_cnt, 16);
        chk("t4_err", last_err, 1);
        chk("t4_beats", b_addr.size(), 0);
        chk("t4_rd_count", rd_got.size(), 0);
        @(negedge clk); #3;
        chk("t4_cmd_ready", cmd_ready, 1);

        // reset in the middle of a write burst
        clear_log(); fix_delay = 0;
        for (int k = 0; k < 8; k++) wq.push_back(32'hBEEF_0000 | k);
        send_cmd(1'b1, 26'h800, 8'd7);
        for (int n = 0; n < 100; n++) begin
            @(negedge clk); #3;
            if (b_addr.size() >= 3) break;
        end
        chk("t5_beats_before", b_addr.size(), 3);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("t5_cyc_drop", wb_cyc_o, 0);
        chk("t5_stb_drop", wb_stb_o, 0);
        wq.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #3;
        chk("t5_no_done", done_cnt, 0);
        chk("t5_no_extra_beat", b_addr.size(), 3);
        clear_log();
        send_cmd(1'b0, 26'h10, 8'd1);
        wait_done(1, 50);
        chk("t5_post_beats", b_addr.size(), 2);
        if (b_addr.size() == 2) begin
            chk("t5_post_addr0", b_addr[0], 26'h10);
            chk("t5_post_addr1", b_addr[1], 26'h14);
            chk("t5_post_cti0", b_cti[0], 3'b010);
            chk("t5_post_cti1", b_cti[1], 3'b111);
        end
        if (rd_got.size() == 2) chk("t5_post_rdat1", rd_got[1], pat(26'h14));
        chk("t5_post_err", last_err, 0);

        // back-to-back single reads; first address is misaligned
        clear_log(); fix_delay = 0;
        send_cmd(1'b0, 26'h207, 8'd0);
        send_cmd(1'b0, 26'h3000, 8'd0);
        wait_done(2, 50);
        chk("t6_beats", b_addr.size(), 2);
        if (b_addr.size() == 2) begin
            chk("t6_align", b_addr[0], 26'h204);
            chk("t6_addr2", b_addr[1], 26'h3000);
        end
        chk("t6_cyc_rises", cyc_rise, 2);
        if (done_cyc.size() >= 1) chk("t6_gap", last_rise_cyc - done_cyc[0], 2);

        // random commands with random ACK latency against a scoreboard
        begin : rnd
            int            total_mis;
            logic [AW-1:0] base;
            logic [DW-1:0] ew[$];
            logic          rwe;
            logic [LW-1:0] rlen;
            logic [2:0]    ecti;
            total_mis = 0;
            rnd_ack = 1'b1;
            for (int n = 0; n < 1000; n++) begin
                clear_log();
                rwe  = 1'($urandom_range(1, 0));
                base = AW'($urandom) & ~AW'(3);
                rlen = LW'($urandom_range(7, 0));
                ew.delete();
                for (int k = 0; k <= int'(rlen); k++) begin
                    ew.push_back($urandom);
                    if (rwe) wq.push_back(ew[k]);
                end
                send_cmd(rwe, base | AW'($urandom_range(3, 0)), rlen);
                wait_done(1, 400);
                if (last_err !== 1'b0) total_mis++;
                if (b_addr.size() != int'(rlen) + 1) begin
                    total_mis++;
                end else begin
                    for (int k = 0; k <= int'(rlen); k++) begin
                        ecti = (k == int'(rlen)) ? 3'b111 : 3'b010;
                        if (b_addr[k] !== base + AW'(4 * k)) total_mis++;
                        if (b_cti[k] !== ecti) total_mis++;
                        if (b_we[k] !== rwe) total_mis++;
                        if (rwe && (b_dat[k] !== ew[k])) total_mis++;
                    end
                end
                if (!rwe) begin
                    if (rd_got.size() != int'(rlen) + 1) begin
                        total_mis++;
                    end else begin
                        for (int k = 0; k <= int'(rlen); k++) begin
                            if (rd_got[k] !== pat(base + AW'(4 * k))) total_mis++;
                        end
                    end
                end
            end
            rnd_ack = 1'b0;
            chk("rnd_scoreboard", total_mis, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_sdrc_wb_burst_master
`default_nettype wire

// File: doc/sdrc_wb_burst_master.md
Name: sdrc_wb_burst_master

Overview:
- Wishbone B3 bus master sitting directly upstream of the SDRAM controller's Wishbone slave port.
- Converts a simple command/stream interface (address, beat count, direction, write-data stream) into Wishbone incrementing-burst cycles.
- Returns read data as a stream.
- Used as the traffic source in front of the SDRAM controller, in bench and in system integration.

Parameters:
- SDR_DW, 32, Wishbone data width in bits (32 or 16); SEL width = SDR_DW/8.
- APP_AW, 26, Wishbone byte-address width.
- LEN_W, 8, command length field width; max burst = 2^LEN_W beats.
- TIMEOUT, 1024, max cycles with STB high and no ACK before abort.

Ports:
- wb_clk_i  in  1  single clock; all logic on rising edge.
- wb_rst_i  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_we  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  APP_AW  start byte address; low log2(SDR_DW/8) bits ignored (forced 0).
- cmd_len  in  LEN_W  beats minus one (0 → 1 beat, 255 → 256 beats).
- wdat_valid  in  1  write-data beat available.
- wdat_ready  out  1  write beat consumed.
- wdat  in  SDR_DW  write data.
- rdat_valid  out  1  one-cycle pulse per returned read beat.
- rdat  out  SDR_DW  read data.
- done  out  1  one-cycle pulse at end of command.
- err  out  1  valid with done; 1 = aborted by timeout.
- wb_cyc_o  out  1  Wishbone CYC.
- wb_stb_o  out  1  Wishbone STB.
- wb_we_o  out  1  Wishbone WE.
- wb_addr_o  out  APP_AW  Wishbone byte address.
- wb_sel_o  out  SDR_DW/8  byte selects; always all-ones.
- wb_cti_o  out  3  cycle type.
- wb_dat_o  out  SDR_DW  write data.
- wb_ack_i  in  1  Wishbone ACK.
- wb_dat_i  in  SDR_DW  read data.

Behaviour:
- Reset (async, while wb_rst_i=1): state IDLE. cmd_ready=1. All Wishbone outputs 0 except wb_sel_o all-ones and wb_cti_o=3'b000. rdat_valid, done, err, wdat_ready = 0.
- Reset asserted mid-burst: CYC/STB drop immediately with no completing beat; done is not pulsed; beats already consumed are lost.
- All Wishbone outputs are registered.
- States: IDLE, ISSUE, FINISH.
- IDLE:
  - cmd_ready=1.
  - On accept: latch we, addr (aligned), and beat counter = cmd_len; clear timeout counter; go to ISSUE next cycle.
- ISSUE:
  - wb_cyc_o=1 throughout.
  - Read: STB=1 every cycle.
  - Write: STB=1 only when a beat is loaded. A beat is loaded from wdat when wdat_valid & (STB low, or STB high & ACK). wdat_ready is high on exactly those load cycles.
  - Write-data starvation: STB drops with CYC held; counts as wait state. The timeout counter does not run while STB is low.
  - Beat advance: on each STB & ACK, address += SDR_DW/8 modulo 2^APP_AW (wrap to 0), counter decrements.
  - Read beats: rdat_valid=1 and rdat=wb_dat_i registered, one cycle after the ACK (1-cycle latency). No backpressure on rdat.
  - CTI: 3'b010 while remaining beats > 1; 3'b111 on the last beat. A single-beat command uses 3'b111 only.
  - Final ACK (counter==0): drop CYC/STB next cycle; go to FINISH.
- Timeout: counter increments each cycle STB=1 & ACK=0 and clears on ACK. At TIMEOUT: drop CYC/STB, go to FINISH with err=1; remaining write beats are not consumed.
- FINISH: pulse done (with err) for one cycle; return to IDLE. cmd_ready is high again in the cycle after done, so the minimum inter-command gap is 2 cycles.
- ACK while STB=0 is ignored.

Decomposition:
- Package sdrc_wb_pkg:
  - CTI constants CTI_CLASSIC=3'b000, CTI_INCR=3'b010, CTI_EOB=3'b111.
  - State enum {IDLE, ISSUE, FINISH}.
- No sub-module; single flat module. The timeout counter may be a local always block.

Test Plan:
- Single write: addr 0x100, len 0, wdat 0xA5A5A5A5 valid, slave ACKs after 2 cycles → one STB, cti 111, addr 0x100, dat 0xA5A5A5A5, done=1, err=0.
- Read burst with wrap: addr 0x3FFFFF8, len 3, zero-wait ACK → addrs 0x3FFFFF8, 0x3FFFFFC, 0x0000000, 0x0000004; cti 010,010,010,111; 4 rdat_valid pulses in order; done.
- Write starvation: len 3, wdat_valid low for 5 cycles after beat 1 → STB low, CYC high during gap; exactly 4 wdat_ready pulses; done with err=0.
- Timeout: read len 1, slave never ACKs, TIMEOUT=16 → CYC drops after 16 STB cycles; done=1, err=1; cmd_ready returns.
- Reset mid-burst: write len 7, assert wb_rst_i after beat 3 ACK → CYC/STB low in the same cycle, no done; next command after release executes normally.
- Back-to-back: two len-0 reads → second CYC starts 2 cycles after first done; random ACK delay 0–7 across 1000 random commands with scoreboard match.
